serial_subtractor: RTL and testbench

//  - Bit-serial, multi-cycle A-B subtractor with borrow; the inverse operation of the team's 4-bit ripple-carry adder.
//  - Processes one bit per clock, LSB first, using a single 1-bit full-subtractor cell.
//  - Used where adder area is too costly and a WIDTH+1 cycle latency is acceptable.
//  - start/done handshake; result held stable until the next accepted start.

---
 rtl/arith_pkg.sv | 21 ++
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 119 +++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: FSM state encoding and a counter-width helper
// for the bit-serial datapaths.
package arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Bits needed to count 0..n-1; never less than one bit.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = x - y - bi, with borrow out bo.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A-B subtractor, LSB first, one full-subtractor cell, WIDTH+1 cycle latency.
// Optional build macro SERIAL_SUB_SATURATE_EN clamps diff to 0 when the result borrows.
//
// Handshake: start is accepted on a rising edge whenever busy is low (IDLE or DONE
// state); a/b are captured on that edge. done pulses for one cycle with diff and
// borrow_out already valid; both then hold until the next operation completes.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output state_e           state_o
);

   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             borrow_q, borrow_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic             borrow_out_q, borrow_out_d;

   logic             fs_d, fs_bo;
   logic [WIDTH-1:0] res_shift;

   full_subtractor u_fs (
      .x  (a_sr_q[0]),
      .y  (b_sr_q[0]),
      .bi (borrow_q),
      .d  (fs_d),
      .bo (fs_bo)
   );

   // Result bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts.
   assign res_shift = {fs_d, res_q[WIDTH-1:1]};

   always_comb begin
      state_d      = state_q;
      a_sr_d       = a_sr_q;
      b_sr_d       = b_sr_q;
      res_d        = res_q;
      borrow_d     = borrow_q;
      cnt_d        = cnt_q;
      diff_d       = diff_q;
      borrow_out_d = borrow_out_q;

      case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (start) begin
               a_sr_d   = a;
               b_sr_d   = b;
               borrow_d = 1'b0;
               cnt_d    = '0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_d    = res_shift;
            borrow_d = fs_bo;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CNT) begin
               state_d      = DONE;
               borrow_out_d = fs_bo;
`ifdef SERIAL_SUB_SATURATE_EN
               diff_d       = fs_bo ? '0 : res_shift;
`else
               diff_d       = res_shift;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_sr_q       <= '0;
         b_sr_q       <= '0;
         res_q        <= '0;
         borrow_q     <= 1'b0;
         cnt_q        <= '0;
         diff_q       <= '0;
         borrow_out_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         a_sr_q       <= a_sr_d;
         b_sr_q       <= b_sr_d;
         res_q        <= res_d;
         borrow_q     <= borrow_d;
         cnt_q        <= cnt_d;
         diff_q       <= diff_d;
         borrow_out_q <= borrow_out_d;
      end
   end

   assign busy       = (state_q == SHIFT);
   assign done       = (state_q == DONE);
   assign diff       = diff_q;
   assign borrow_out = borrow_out_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive checks of serial_subtractor (WIDTH=4); honours SERIAL_SUB_SATURATE_EN.
module tb_serial_subtractor;

   localparam int W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [W-1:0]     a = '0;
   logic [W-1:0]     b = '0;
   logic             busy, done, borrow_out;
   logic [W-1:0]     diff;
   arith_pkg::state_e state_o;

   int               checks = 0;
   int               errors = 0;
   logic [W:0]       exp_q[$];
   logic [W-1:0]     held_diff = '0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .a          (a),
      .b          (b),
      .busy       (busy),
      .done       (done),
      .diff       (diff),
      .borrow_out (borrow_out),
      .state_o    (state_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Unsigned reference: {borrow, diff} of a-b, optionally clamped.
   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W:0] r;
      r = {1'b0, x} - {1'b0, y};
`ifdef SERIAL_SUB_SATURATE_EN
      if (r[W]) r[W-1:0] = '0;
`endif
      return r;
   endfunction

   // Waits (bounded) for done; diff must hold its last value until then.
   task automatic wait_done(input string tag, output int cyc, output bit got, output int busy_n);
      cyc = 0;
      got = 1'b0;
      busy_n = 0;
      while (cyc < 12 && !got) begin
         @(negedge clk);
         cyc++;
         if (done) got = 1'b1;
         else begin
            if (busy) busy_n++;
            check({tag, "_diff_held"}, 32'(diff), 32'(held_diff));
         end
      end
      check({tag, "_done_seen"}, 32'(got), 32'd1);
   endtask

   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] ed, input logic eb, input string tag);
      int cyc, busy_n;
      bit got;
      logic [W:0] e;
      exp_q.push_back({eb, ed});
      @(negedge clk);
      a = x;
      b = y;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(tag, cyc, got, busy_n);
      e = exp_q.pop_front();
      if (got) begin
         check({tag, "_latency"}, 32'(cyc), 32'd5);
         check({tag, "_busy_cycles"}, 32'(busy_n), 32'd4);
         check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
         check({tag, "_diff"}, 32'(diff), 32'(e[W-1:0]));
         check({tag, "_borrow"}, 32'(borrow_out), 32'(e[W]));
         held_diff = diff;
      end
   endtask

   initial begin
      int cyc, busy_n;
      bit got;
      logic [W:0] e;
      bit seen_done;

      // Reset state
      #2;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow_out), 32'd0);
      check("rst_state", 32'(state_o), 32'(arith_pkg::IDLE));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic and negative results
      run_op(4'd9, 4'd5, 4'd4, 1'b0, "t1_9m5");
`ifdef SERIAL_SUB_SATURATE_EN
      run_op(4'd5, 4'd9, 4'd0, 1'b1, "t2_5m9");
      run_op(4'd0, 4'd1, 4'd0, 1'b1, "t3_0m1");
`else
      run_op(4'd5, 4'd9, 4'd12, 1'b1, "t2_5m9");
      run_op(4'd0, 4'd1, 4'd15, 1'b1, "t3_0m1");
`endif
      run_op(4'd15, 4'd15, 4'd0, 1'b0, "t3_15m15");
      run_op(4'd15, 4'd0, 4'd15, 1'b0, "t3_15m0");

      // Start held high: operand change mid-SHIFT, then back-to-back from DONE
      @(negedge clk);
      a = 4'd9;
      b = 4'd5;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      @(negedge clk);
      a = 4'd7;
      b = 4'd2;
      wait_done("t4_op1", cyc, got, busy_n);
      check("t4_op1_remaining", 32'(cyc), 32'd3);
      check("t4_op1_diff", 32'(diff), 32'd4);
      check("t4_op1_borrow", 32'(borrow_out), 32'd0);
      held_diff = diff;
      wait_done("t4_op2", cyc, got, busy_n);
      start = 1'b0;
      check("t4_op2_gap", 32'(cyc), 32'd5);
      check("t4_op2_busy_cycles", 32'(busy_n), 32'd4);
      check("t4_op2_diff", 32'(diff), 32'd5);
      check("t4_op2_borrow", 32'(borrow_out), 32'd0);
      held_diff = diff;
      @(negedge clk);
      check("t4_idle_busy", 32'(busy), 32'd0);
      check("t4_idle_done", 32'(done), 32'd0);
      check("t4_idle_state", 32'(state_o), 32'(arith_pkg::IDLE));

      // Reset asserted during the second SHIFT cycle
      @(negedge clk);
      a = 4'd9;
      b = 4'd5;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      check("t5_rst_diff", 32'(diff), 32'd0);
      check("t5_rst_borrow", 32'(borrow_out), 32'd0);
      check("t5_rst_state", 32'(state_o), 32'(arith_pkg::IDLE));
      held_diff = '0;
      seen_done = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) seen_done = 1'b1;
      end
      check("t5_no_done", 32'(seen_done), 32'd0);
      check("t5_diff_after", 32'(diff), 32'd0);
      run_op(4'd3, 4'd1, 4'd2, 1'b0, "t5_3m1");

      // Exhaustive sweep against the arithmetic reference
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            e = model(W'(i), W'(j));
            run_op(W'(i), W'(j), e[W-1:0], e[W], "t6_sweep");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
